sd_dat_rx_ctrl: RTL and testbench
=================================

Name: sd_dat_rx_ctrl

Overview:
Hardware sequencer for SD 4-bit DAT block reads. It replaces software bit-banging of the DAT port. An Avalon-MM slave arms the block. The block then waits for the start bit, assembles nibbles into bytes and checks CRC16 on each of the 4 lines. Bytes go into a small FIFO that the CPU drains. It sits beside the SD clock generator and throttles that generator when the FIFO fills.

Parameters:
FIFO_DEPTH, 16, byte entries in the receive FIFO (power of 2, at least 4)
BLKLEN_DEFAULT, 512, reset value of the BLKLEN register (bytes per block)
TIMEOUT_DEFAULT, 16'hFFFF, reset value of the TIMEOUT register (SD-clock ticks)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  3  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
read_n  in  1  active-low read strobe (only needed for FIFO pop side effect)
writedata  in  32  write data
readdata  out  32  registered read data
sd_strobe  in  1  one-clk pulse from the clock generator marking the DAT sample point
sd_dat_in  in  4  DAT[3:0] input from the pad
sd_clk_en  out  1  permits the clock generator to run the SD clock
irq  out  1  interrupt, level

Behaviour:
- Reset values: readdata=0, irq=0, sd_clk_en=1, state=IDLE, FIFO empty, all flags 0, BLKLEN=BLKLEN_DEFAULT, TIMEOUT=TIMEOUT_DEFAULT, ien=0.
- Register map:
  - 0 CTRL: write bit0=start, bit1=abort, bit2=ien (stored). Reads ien in bit2.
  - 1 STATUS (RO): bit0 busy, bit1 done, bit2 crc_err, bit3 timeout, bit4 ovf, bit5 fifo_empty, bit6 fifo_full, [15:8] fifo level.
  - 2 DATA (RO): [7:0] FIFO head.
  - 3 BLKLEN [9:0]: 0 means 1024.
  - 4 TIMEOUT [15:0].
  - All other addresses read 0.
- Read timing:
  - readdata is registered every clk from the address mux, so there is 1-cycle latency.
  - A DATA read with chipselect & ~read_n & FIFO non-empty loads the head byte into readdata and pops on the same edge.
  - A DATA read on an empty FIFO returns 0 and does not pop.
- start:
  - Ignored while busy.
  - Otherwise clears done, crc_err, timeout and ovf, flushes the FIFO, loads the timeout counter from TIMEOUT and the nibble counter from 2*BLKLEN, zeroes the four CRCs, and enters WAIT_START.
- abort:
  - Has priority over start in the same write.
  - Forces IDLE from any state, flushes the FIFO and sets sd_clk_en=1.
  - Flags are left unchanged; done is not set.
- FSM (advances only on sd_strobe unless stated otherwise):
  - IDLE: busy=0.
  - WAIT_START:
    - sd_dat_in==4'b0000 goes to DATA.
    - Otherwise the counter decrements. At a strobe with counter==0, set timeout and go to IDLE.
  - DATA:
    - Each strobe captures one nibble, high nibble first.
    - Every second nibble pushes a byte.
    - Each line's CRC updates with its bit.
    - After the last nibble (counter reaches 0), go to CRC with a bit counter of 16.
  - CRC:
    - For 16 strobes, compare sd_dat_in[i] with crc[i][15] for each line, then shift that CRC left.
    - Any mismatch sets crc_err.
    - After 16 strobes go to END.
  - END: one strobe. sd_dat_in!=4'b1111 sets crc_err. Then set done and go to IDLE.
- CRC16 per line:
  - Polynomial 0x1021, init 0, MSB first.
  - Per bit: fb = crc[15]^bit; crc = {crc[14:0],1'b0} ^ (fb ? 16'h1021 : 0).
- FIFO:
  - Push and pop on the same edge leave the level unchanged.
  - A push when full drops the byte and sets ovf; the block completes normally.
- Flow control:
  - sd_clk_en is registered.
  - It is 0 when state==DATA and level >= FIFO_DEPTH-2, otherwise 1.
  - The clock generator must issue no more than 1 strobe after sd_clk_en falls.
- irq = ien & (done | timeout), registered.
- Status flags are sticky until the next start.
- Asserting reset_n low mid-block returns every register and the FSM to its reset values immediately.

Test Plan:
1. Reset, then read STATUS → readdata=0x00000020 one cycle after the read (fifo_empty=1), and sd_clk_en=1.
2. BLKLEN=4, start, then drive 0000, nibbles of bytes A5 3C 0F F0, correct per-line CRCs, then 1111 → FIFO drains A5,3C,0F,F0; done=1, crc_err=0; irq=1 with ien=1.
3. Same as test 2 but flip one bit of the line-2 CRC → done=1, crc_err=1; data is still delivered.
4. TIMEOUT=3, start, hold DAT=1111 → timeout=1 on the 4th strobe, busy=0, done=0.
5. BLKLEN=32 with no CPU reads and continuous strobes → sd_clk_en=0 once level reaches 14. Popping 2 bytes returns sd_clk_en to 1. With a misbehaving generator that keeps strobing, ovf=1 and level saturates at 16.
6. Abort mid-DATA, then start with BLKLEN=1 and a valid 1-byte block 0x81 → the FIFO holds only 0x81 and done=1; a start write while busy is ignored.

Source files
------------

// File: rtl/sd_dat_rx_ctrl_if.sv
// -----------------------------------------------------------------------------
// sd_dat_rx_ctrl_if
//   Avalon-MM register port of the SD DAT receive sequencer.
//
//   address    : register select (3 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   read_n     : active-low read strobe (pops the FIFO on DATA reads)
//   writedata  : 32-bit write data
//   readdata   : 32-bit registered read data (1-cycle latency)
//
//   master : the CPU / interconnect side
//   slave  : the sd_dat_rx_ctrl side
// -----------------------------------------------------------------------------
interface sd_dat_rx_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, read_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, read_n, writedata,
    output readdata
  );
endinterface

// File: rtl/sd_dat_rx_ctrl.sv
// -----------------------------------------------------------------------------
// sd_dat_rx_ctrl
//   Hardware sequencer for SD 4-bit DAT block reads. Once armed over the
//   register port it waits for the start bit, assembles nibbles into bytes
//   (high nibble first), runs a CRC16 per DAT line, checks the received CRCs
//   and the end bit, and queues the bytes in a small FIFO for the CPU. While
//   receiving data it throttles the SD clock generator when the FIFO nears
//   full.
//
// Ports
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   bus        : Avalon-MM slave (address/chipselect/write_n/read_n/
//                writedata/readdata)
//   sd_strobe  : one-clk pulse marking the DAT sample point
//   sd_dat_in  : DAT[3:0] from the pad
//   sd_clk_en  : permits the clock generator to run the SD clock (registered)
//   irq        : level interrupt, ien & (done | timeout), registered
//
// Register map
//   0 CTRL    W: bit0 start, bit1 abort, bit2 ien   R: bit2 ien
//   1 STATUS  R: bit0 busy, bit1 done, bit2 crc_err, bit3 timeout, bit4 ovf,
//                bit5 fifo_empty, bit6 fifo_full, [15:8] fifo level
//   2 DATA    R: [7:0] FIFO head (read with read_n low pops)
//   3 BLKLEN  RW [9:0] bytes per block, 0 means 1024
//   4 TIMEOUT RW [15:0] strobes to wait for the start bit
// -----------------------------------------------------------------------------
module sd_dat_rx_ctrl #(
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned BLKLEN_DEFAULT  = 512,
  parameter logic [15:0] TIMEOUT_DEFAULT = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sd_dat_rx_ctrl_if.slave       bus,
  input  logic                  sd_strobe,
  input  logic [3:0]            sd_dat_in,
  output logic                  sd_clk_en,
  output logic                  irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_STATUS  = 3'd1;
  localparam logic [2:0] ADDR_DATA    = 3'd2;
  localparam logic [2:0] ADDR_BLKLEN  = 3'd3;
  localparam logic [2:0] ADDR_TIMEOUT = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_DATA,
    ST_CRC,
    ST_END
  } state_t;

  // One CRC16 step (poly 0x1021, MSB first) for a single DAT line.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc_in,
                                             input logic        bit_in);
    logic fb;
    fb = crc_in[15] ^ bit_in;
    return {crc_in[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t            state, state_next;
  logic [15:0]       tmo_cnt, tmo_next;
  logic [11:0]       nib_cnt, nib_next;   // nibbles left; 2*1024 needs 12 bits
  logic [4:0]        bit_cnt, bit_next;   // CRC bits left
  logic [3:0]        hi_nib, hi_next;
  logic [3:0][15:0]  crc, crc_next;

  logic              ien;
  logic [9:0]        blklen;
  logic [15:0]       timeout_reg;
  logic              done, crc_err, timeout_flag, ovf;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level, level_next;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic wr_en, rd_en, ctrl_wr, start, abort;
  logic [10:0] blk_bytes;

  assign wr_en   = bus.chipselect & ~bus.write_n;
  assign rd_en   = bus.chipselect & ~bus.read_n;
  assign ctrl_wr = wr_en && (bus.address == ADDR_CTRL);

  // Abort wins over start in the same write; start is ignored while busy.
  assign abort   = ctrl_wr & bus.writedata[1];
  assign start   = ctrl_wr & bus.writedata[0] & ~bus.writedata[1] &
                   (state == ST_IDLE);

  assign blk_bytes = (blklen == 10'd0) ? 11'd1024 : {1'b0, blklen};

  // Upper write-data bits have no register behind them.
  logic unused_bits;
  assign unused_bits = ^bus.writedata[31:16];

  // ---------------------------------------------------------------------------
  // FIFO status and handshakes
  // ---------------------------------------------------------------------------
  logic       fifo_empty, fifo_full;
  logic       push, push_ok, pop, flush;
  logic [7:0] push_byte;
  logic       set_done, set_crc_err, set_timeout, set_ovf;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LW'(FIFO_DEPTH));
  assign flush      = abort | start;
  assign pop        = rd_en && (bus.address == ADDR_DATA) && !fifo_empty && !flush;
  // A push into a full FIFO still fits when a pop frees a slot on the same edge.
  assign push_ok    = push && (!fifo_full || pop);
  assign set_ovf    = push && !push_ok;

  always_comb begin
    level_next = level;
    if (flush) begin
      level_next = '0;
    end else begin
      unique case ({push_ok, pop})
        2'b10:   level_next = level + LW'(1);
        2'b01:   level_next = level - LW'(1);
        default: level_next = level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and datapath updates
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first so that no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    tmo_next    = tmo_cnt;
    nib_next    = nib_cnt;
    bit_next    = bit_cnt;
    hi_next     = hi_nib;
    crc_next    = crc;
    push        = 1'b0;
    push_byte   = '0;
    set_done    = 1'b0;
    set_crc_err = 1'b0;
    set_timeout = 1'b0;

    if (abort) begin
      state_next = ST_IDLE;
    end else if (start) begin
      state_next = ST_WAIT_START;
      tmo_next   = timeout_reg;
      nib_next   = {blk_bytes, 1'b0};
      bit_next   = '0;
      crc_next   = '0;
    end else if (sd_strobe) begin
      unique case (state)
        ST_IDLE: ;

        ST_WAIT_START: begin
          if (sd_dat_in == 4'b0000) begin
            state_next = ST_DATA;
          end else if (tmo_cnt == 16'd0) begin
            set_timeout = 1'b1;
            state_next  = ST_IDLE;
          end else begin
            tmo_next = tmo_cnt - 16'd1;
          end
        end

        ST_DATA: begin
          for (int i = 0; i < 4; i++) begin
            crc_next[i] = crc16_step(crc[i], sd_dat_in[i]);
          end
          // The counter starts even, so an even count marks the high nibble.
          if (!nib_cnt[0]) begin
            hi_next = sd_dat_in;
          end else begin
            push      = 1'b1;
            push_byte = {hi_nib, sd_dat_in};
          end
          nib_next = nib_cnt - 12'd1;
          if (nib_cnt == 12'd1) begin
            state_next = ST_CRC;
            bit_next   = 5'd16;
          end
        end

        ST_CRC: begin
          for (int i = 0; i < 4; i++) begin
            if (sd_dat_in[i] != crc[i][15]) set_crc_err = 1'b1;
            crc_next[i] = {crc[i][14:0], 1'b0};
          end
          bit_next = bit_cnt - 5'd1;
          if (bit_cnt == 5'd1) state_next = ST_END;
        end

        ST_END: begin
          if (sd_dat_in != 4'b1111) set_crc_err = 1'b1;
          set_done   = 1'b1;
          state_next = ST_IDLE;
        end

        default: state_next = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      tmo_cnt      <= '0;
      nib_cnt      <= '0;
      bit_cnt      <= '0;
      hi_nib       <= '0;
      crc          <= '0;
      ien          <= 1'b0;
      blklen       <= 10'(BLKLEN_DEFAULT);
      timeout_reg  <= TIMEOUT_DEFAULT;
      done         <= 1'b0;
      crc_err      <= 1'b0;
      timeout_flag <= 1'b0;
      ovf          <= 1'b0;
      sd_clk_en    <= 1'b1;
      irq          <= 1'b0;
    end else begin
      state   <= state_next;
      tmo_cnt <= tmo_next;
      nib_cnt <= nib_next;
      bit_cnt <= bit_next;
      hi_nib  <= hi_next;
      crc     <= crc_next;

      if (ctrl_wr) ien <= bus.writedata[2];
      if (wr_en && bus.address == ADDR_BLKLEN)  blklen      <= bus.writedata[9:0];
      if (wr_en && bus.address == ADDR_TIMEOUT) timeout_reg <= bus.writedata[15:0];

      if (start) begin
        done         <= 1'b0;
        crc_err      <= 1'b0;
        timeout_flag <= 1'b0;
        ovf          <= 1'b0;
      end else begin
        if (set_done)    done         <= 1'b1;
        if (set_crc_err) crc_err      <= 1'b1;
        if (set_timeout) timeout_flag <= 1'b1;
        if (set_ovf)     ovf          <= 1'b1;
      end

      // Look at next-cycle state and level so the generator is stopped on
      // the same edge that fills the FIFO to DEPTH-2.
      if (abort) sd_clk_en <= 1'b1;
      else       sd_clk_en <= !(state_next == ST_DATA &&
                                level_next >= LW'(FIFO_DEPTH - 2));

      irq <= ien & (done | timeout_flag);
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      level <= level_next;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop)     rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // NOTE: the storage array has no reset; the level counter alone decides
  // which entries are valid, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_byte;
  end

  // ---------------------------------------------------------------------------
  // Registered read mux
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else begin
      unique case (bus.address)
        ADDR_CTRL:    bus.readdata <= {29'd0, ien, 2'b00};
        ADDR_STATUS:  bus.readdata <= {16'd0, 8'(level), 1'b0, fifo_full,
                                       fifo_empty, ovf, timeout_flag, crc_err,
                                       done, (state != ST_IDLE)};
        ADDR_DATA:    bus.readdata <= fifo_empty ? 32'd0 : {24'd0, mem[rd_ptr]};
        ADDR_BLKLEN:  bus.readdata <= {22'd0, blklen};
        ADDR_TIMEOUT: bus.readdata <= {16'd0, timeout_reg};
        default:      bus.readdata <= 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_dat_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sd_dat_rx_ctrl
//   Self-checking bench for sd_dat_rx_ctrl. Bytes sent on DAT go through a
//   FIFO model into a scoreboard queue and are compared as the CPU drains.
// -----------------------------------------------------------------------------
module tb_sd_dat_rx_ctrl;

  localparam int DEPTH = 16;

  localparam logic [2:0] A_CTRL    = 3'd0;
  localparam logic [2:0] A_STATUS  = 3'd1;
  localparam logic [2:0] A_DATA    = 3'd2;
  localparam logic [2:0] A_BLKLEN  = 3'd3;
  localparam logic [2:0] A_TIMEOUT = 3'd4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sd_strobe;
  logic [3:0] sd_dat_in;
  logic       sd_clk_en;
  logic       irq;

  sd_dat_rx_ctrl_if bus ();

  sd_dat_rx_ctrl #(
    .FIFO_DEPTH      (DEPTH),
    .BLKLEN_DEFAULT  (512),
    .TIMEOUT_DEFAULT (16'hFFFF)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .sd_strobe (sd_strobe),
    .sd_dat_in (sd_dat_in),
    .sd_clk_en (sd_clk_en),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  sb [$];
  logic [15:0] m_crc [4];
  logic [31:0] rd;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return (c << 1) ^ ({16{fb}} & 16'h1021);
  endfunction

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.read_n     = 1'b0;
    @(negedge clk);
    d              = bus.readdata;
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
  endtask

  task automatic strobe(input logic [3:0] d);
    @(negedge clk);
    sd_strobe = 1'b1;
    sd_dat_in = d;
    @(negedge clk);
    sd_strobe = 1'b0;
    sd_dat_in = 4'hF;
  endtask

  task automatic send_start();
    for (int i = 0; i < 4; i++) m_crc[i] = 16'h0000;
    strobe(4'b0000);
  endtask

  task automatic send_nibble(input logic [3:0] n);
    for (int i = 0; i < 4; i++) m_crc[i] = ref_crc(m_crc[i], n[i]);
    strobe(n);
  endtask

  // Sends one byte and records what a DEPTH-entry FIFO would keep.
  task automatic send_byte(input logic [7:0] b);
    send_nibble(b[7:4]);
    send_nibble(b[3:0]);
    if (sb.size() < DEPTH) sb.push_back(b);
  endtask

  task automatic send_crc(input logic [3:0] flip_lines, input int flip_k);
    logic [3:0] n;
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 4; i++) n[i] = m_crc[i][15-k];
      if (k == flip_k) n = n ^ flip_lines;
      strobe(n);
    end
  endtask

  task automatic drain(input int n, input string tag);
    logic [31:0] d;
    logic [7:0]  e;
    for (int i = 0; i < n; i++) begin
      bus_read(A_DATA, d);
      e = (sb.size() != 0) ? sb.pop_front() : 8'h00;
      check(tag, d, {24'd0, e});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    sd_strobe      = 1'b0;
    sd_dat_in      = 4'hF;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.read_n     = 1'b1;
    bus.writedata  = '0;

    // 1: reset values
    repeat (3) @(negedge clk);
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_clk_en", {31'd0, sd_clk_en}, 32'h1);
    check("rst_irq", {31'd0, irq}, 32'h0);
    reset_n = 1'b1;
    bus_read(A_STATUS, rd);  check("rst_status", rd, 32'h0000_0020);
    bus_read(A_BLKLEN, rd);  check("rst_blklen", rd, 32'd512);
    bus_read(A_TIMEOUT, rd); check("rst_timeout", rd, 32'h0000_FFFF);
    bus_read(A_CTRL, rd);    check("rst_ctrl", rd, 32'h0);

    // 2: good 4-byte block
    bus_write(A_BLKLEN, 32'd4);
    bus_write(A_CTRL, 32'h5);
    bus_read(A_STATUS, rd);  check("t2_busy", rd, 32'h0000_0021);
    send_start();
    send_byte(8'hA5); send_byte(8'h3C); send_byte(8'h0F); send_byte(8'hF0);
    send_crc(4'b0000, -1);
    strobe(4'b1111);
    bus_read(A_STATUS, rd);  check("t2_status", rd, 32'h0000_0402);
    check("t2_irq", {31'd0, irq}, 32'h1);
    drain(4, "t2_data");
    bus_read(A_STATUS, rd);  check("t2_empty", rd, 32'h0000_0022);
    bus_read(A_DATA, rd);    check("t2_empty_read", rd, 32'h0);

    // 3: line-2 CRC bit flipped
    bus_write(A_CTRL, 32'h5);
    send_start();
    send_byte(8'hA5); send_byte(8'h3C); send_byte(8'h0F); send_byte(8'hF0);
    send_crc(4'b0100, 5);
    strobe(4'b1111);
    bus_read(A_STATUS, rd);  check("t3_status", rd, 32'h0000_0406);
    drain(4, "t3_data");

    // 4: start-bit timeout
    bus_write(A_TIMEOUT, 32'd3);
    bus_write(A_CTRL, 32'h5);
    repeat (3) strobe(4'b1111);
    bus_read(A_STATUS, rd);  check("t4_waiting", rd, 32'h0000_0021);
    check("t4_irq_low", {31'd0, irq}, 32'h0);
    strobe(4'b1111);
    bus_read(A_STATUS, rd);  check("t4_status", rd, 32'h0000_0028);
    check("t4_irq", {31'd0, irq}, 32'h1);

    // 5: flow control and overflow
    bus_write(A_BLKLEN, 32'd32);
    bus_write(A_CTRL, 32'h5);
    send_start();
    for (int b = 0; b < 14; b++) begin
      if (b == 13) check("t5_clk_en_13", {31'd0, sd_clk_en}, 32'h1);
      send_byte(8'(b * 7 + 3));
    end
    check("t5_clk_en_off", {31'd0, sd_clk_en}, 32'h0);
    bus_read(A_STATUS, rd);  check("t5_level14", rd, 32'h0000_0E01);
    drain(2, "t5_pop");
    check("t5_clk_en_on", {31'd0, sd_clk_en}, 32'h1);
    for (int b = 14; b < 32; b++) send_byte(8'(b * 7 + 3));
    send_crc(4'b0000, -1);
    strobe(4'b1111);
    bus_read(A_STATUS, rd);  check("t5_status", rd, 32'h0000_1052);
    check("t5_clk_en_idle", {31'd0, sd_clk_en}, 32'h1);
    drain(16, "t5_data");

    // 6: abort mid-DATA, then a 1-byte block with an ignored restart
    bus_write(A_BLKLEN, 32'd4);
    bus_write(A_CTRL, 32'h5);
    send_start();
    send_byte(8'h11); send_byte(8'h22);
    send_nibble(4'h3);
    bus_write(A_CTRL, 32'h7);
    sb.delete();
    bus_read(A_STATUS, rd);  check("t6_aborted", rd, 32'h0000_0020);
    check("t6_clk_en", {31'd0, sd_clk_en}, 32'h1);
    bus_write(A_BLKLEN, 32'd1);
    bus_write(A_CTRL, 32'h5);
    send_start();
    send_byte(8'h81);
    bus_write(A_CTRL, 32'h5);
    send_crc(4'b0000, -1);
    strobe(4'b1111);
    bus_read(A_STATUS, rd);  check("t6_status", rd, 32'h0000_0102);
    drain(1, "t6_data");
    bus_read(A_STATUS, rd);  check("t6_empty", rd, 32'h0000_0022);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
